tlut_dot_engine: RTL
====================

Name: tlut_dot_engine

Overview:
- Parametrised next-generation temporal-LUT SIMD cell.
- Each lane multiplies an unsigned input by an unsigned weight temporally: the lane adds its input once per cycle while a shared time counter is below the lane's weight.
- A registered adder tree reduces the lane products to a dot product, which optionally accumulates across jobs with saturation.
- Adds a valid/ready job handshake, generic lane count, an early-exit mode and a sticky saturation flag.

Parameters:
- LANES, 9, number of SIMD lanes.
- INPUT_WIDTH, 4, unsigned input width per lane.
- WEIGHT_WIDTH, 4, unsigned weight width per lane.
- ACC_WIDTH, 20, running accumulator width; must be >= SUM_WIDTH.
- EARLY_EXIT, 1, 1 = run length is max lane weight; 0 = fixed 2^WEIGHT_WIDTH-1 cycles.
- Derived (localparam): PROD_WIDTH = INPUT_WIDTH+WEIGHT_WIDTH; SUM_WIDTH = PROD_WIDTH+$clog2(LANES).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  engine can accept a job.
- input_bin  in  LANES*INPUT_WIDTH  lane l at bits [l*INPUT_WIDTH +: INPUT_WIDTH].
- weight_bin  in  LANES*WEIGHT_WIDTH  lane l at bits [l*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- acc_clear  in  1  sampled with the job; 1 = accumulator restarts from this job's sum.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- dot_out  out  SUM_WIDTH  this job's dot product.
- acc_out  out  ACC_WIDTH  running saturated accumulation.
- acc_sat  out  1  sticky flag, set when the accumulator has saturated.
- busy  out  1  state != IDLE.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset (rst high at a rising edge):
  - State goes to IDLE; time counter, lane partials, dot_out, acc_out and acc_sat all go to 0.
  - out_valid and busy are 0.
  - in_ready is forced to 0 while rst is high.
  - Reset mid-job abandons the job: no out_valid, accumulator cleared.
- States: IDLE, RUN, TREE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch input_bin, weight_bin and acc_clear; clear the partials and the counter; go to RUN.
  - Compute N:
    - EARLY_EXIT=1: N = max(1, max lane weight).
    - EARLY_EXIT=0: N = 2^WEIGHT_WIDTH-1.
- RUN (exactly N cycles, counter t = 0..N-1):
  - Each lane: if weight[l] > t, then partial[l] += input[l].
  - Partials are PROD_WIDTH wide and never overflow.
  - When t == N-1, go to TREE.
  - After RUN, partial[l] == input[l]*weight[l].
- TREE (1 cycle):
  - dot_out <= sum of all partials (SUM_WIDTH, exact).
  - Accumulator operand is 0 if latched acc_clear, else acc_out.
  - acc_out <= min(operand + sum, 2^ACC_WIDTH-1).
  - If the min clamps, acc_sat <= 1.
  - acc_clear=1 also clears acc_sat before evaluating the new sum.
  - Go to DONE.
- DONE:
  - out_valid=1; dot_out and acc_out are held stable.
  - On out_ready, go to IDLE.
- Handshake:
  - Inputs are accepted only in IDLE, so there is no overlap.
  - The result is consumed on the edge where out_valid&&out_ready.
  - A job can be accepted the cycle after the result is consumed.
- Latency: out_valid rises N+1 edges after the accept edge.
- in_valid while busy is ignored and not queued; upstream holds it until in_ready.
- Weight 0 lane contributes 0.
- All-zero weights with EARLY_EXIT=1 still run 1 cycle.
- acc_out and acc_sat retain their value across idle periods until acc_clear or rst.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, acc_out=0; one cycle after release in_ready=1.
- Basic job: lanes 0..7 inputs=weights={8,7,6,5,3,2,1,0}, lane 8 = 0, acc_clear=1, EARLY_EXIT=1 -> N=8, out_valid 9 edges after accept, dot_out=188, acc_out=188, acc_sat=0.
- Accumulate plus backpressure: repeat the job with acc_clear=0 and out_ready low 5 cycles -> acc_out=376, outputs stable, in_ready=0 throughout; IDLE the edge after out_ready.
- Full range, EARLY_EXIT=0: all inputs and weights 15 -> 15 RUN cycles, dot_out=2025. All-zero weights -> 15 RUN cycles, dot_out=0.
- Saturation (ACC_WIDTH=12, all inputs and weights 15): job with clear -> 2025; then 4050; third job -> acc_out=4095, acc_sat=1; next job with acc_clear=1 -> acc_out=2025, acc_sat=0.
- Reset mid-RUN: assert rst on RUN cycle 3 for 1 cycle -> no out_valid, acc_out=0, in_ready=1 one cycle after release; next job computes correctly.

Source files
------------

// File: rtl/tlut_dot_engine.sv
// Temporal-LUT SIMD dot-product cell: each lane multiplies by repeated addition
// over a shared time counter, then one registered reduction feeds a saturating accumulator.
module tlut_dot_engine #(
   parameter int LANES        = 9,
   parameter int INPUT_WIDTH  = 4,
   parameter int WEIGHT_WIDTH = 4,
   parameter int ACC_WIDTH    = 20,
   parameter int EARLY_EXIT   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*INPUT_WIDTH-1:0]  input_bin,
   input  logic [LANES*WEIGHT_WIDTH-1:0] weight_bin,
   input  logic                          acc_clear,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INPUT_WIDTH+WEIGHT_WIDTH+$clog2(LANES)-1:0] dot_out,
   output logic [ACC_WIDTH-1:0]          acc_out,
   output logic                          acc_sat,
   output logic                          busy
);

   localparam int PROD_WIDTH = INPUT_WIDTH + WEIGHT_WIDTH;
   localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(LANES);
   localparam logic [WEIGHT_WIDTH-1:0] FIXED_LAST = WEIGHT_WIDTH'((2 ** WEIGHT_WIDTH) - 2);
   localparam logic [ACC_WIDTH-1:0]    ACC_MAX    = {ACC_WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, TREE, DONE} state_t;

   state_t                        state_reg, state_next;
   logic [WEIGHT_WIDTH-1:0]       t_reg;
   logic [WEIGHT_WIDTH-1:0]       last_reg, last_next;
   logic [LANES*INPUT_WIDTH-1:0]  in_lat_reg;
   logic [LANES*WEIGHT_WIDTH-1:0] w_lat_reg;
   logic                          clr_reg;
   logic [PROD_WIDTH-1:0]         partial_reg [LANES];
   logic [SUM_WIDTH-1:0]          dot_reg, sum_next;
   logic [ACC_WIDTH-1:0]          acc_reg, acc_operand;
   logic [ACC_WIDTH:0]            acc_total;
   logic                          sat_reg;
   logic [WEIGHT_WIDTH-1:0]       max_weight;
   logic                          accept;

   assign in_ready  = (state_reg == IDLE) && !rst;
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign dot_out   = dot_reg;
   assign acc_out   = acc_reg;
   assign acc_sat   = sat_reg;
   assign accept    = in_valid && in_ready;

   always_comb begin
      max_weight = '0;
      for (int l = 0; l < LANES; l++) begin
         if (weight_bin[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] > max_weight)
            max_weight = weight_bin[l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   // Run length minus one; an all-zero job still spends one cycle in RUN.
   always_comb begin
      last_next = FIXED_LAST;
      if (EARLY_EXIT != 0)
         last_next = (max_weight == '0) ? '0 : max_weight - 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = RUN;
         RUN:  if (t_reg == last_reg) state_next = TREE;
         TREE: state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         t_reg      <= '0;
         last_reg   <= '0;
         in_lat_reg <= '0;
         w_lat_reg  <= '0;
         clr_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            t_reg      <= '0;
            last_reg   <= last_next;
            in_lat_reg <= input_bin;
            w_lat_reg  <= weight_bin;
            clr_reg    <= acc_clear;
         end else if (state_reg == RUN) begin
            t_reg <= t_reg + 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [INPUT_WIDTH-1:0]  lane_in;
         logic [WEIGHT_WIDTH-1:0] lane_w;
         assign lane_in = in_lat_reg[gi*INPUT_WIDTH +: INPUT_WIDTH];
         assign lane_w  = w_lat_reg[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];

         always_ff @(posedge clk) begin
            if (rst || accept)
               partial_reg[gi] <= '0;
            else if (state_reg == RUN && lane_w > t_reg)
               partial_reg[gi] <= partial_reg[gi] + PROD_WIDTH'(lane_in);
         end
      end
   endgenerate

   always_comb begin
      sum_next = '0;
      for (int l = 0; l < LANES; l++)
         sum_next = sum_next + SUM_WIDTH'(partial_reg[l]);
   end

   assign acc_operand = clr_reg ? '0 : acc_reg;
   assign acc_total   = {1'b0, acc_operand} + (ACC_WIDTH + 1)'(sum_next);

   // A cleared job also drops the sticky flag unless it saturates on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         dot_reg <= '0;
         acc_reg <= '0;
         sat_reg <= 1'b0;
      end else if (state_reg == TREE) begin
         dot_reg <= sum_next;
         if (acc_total[ACC_WIDTH]) begin
            acc_reg <= ACC_MAX;
            sat_reg <= 1'b1;
         end else begin
            acc_reg <= acc_total[ACC_WIDTH-1:0];
            sat_reg <= clr_reg ? 1'b0 : sat_reg;
         end
      end
   end

endmodule
